// File: rtl/shot_pool.sv
// Pool of player projectiles: fire allocates the lowest free slot, move ticks advance every live shot,
// and shots retire on delete, lifetime expiry or (no-wrap mode) leaving the screen.

module shot_slot #(
  parameter int COORD_W   = 10,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int WRAP_MODE = 1,
  parameter int LIFETIME  = 60,
  parameter int AGE_W     = 6,
  parameter int ES        = 2*COORD_W+14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          alloc_i,
  input  logic          del_i,
  input  logic          tick_i,
  input  logic [ES-1:0] new_i,
  output logic [ES-1:0] slot_o
);
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(SCREEN_W-1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H-1);
  localparam logic [AGE_W-1:0]   AGE_LAST = AGE_W'(LIFETIME > 0 ? LIFETIME-1 : 0);

  logic [ES-1:0]      slot_q, slot_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               vld;
  logic [2:0]         ent;
  logic [1:0]         xq, yq, eqx, eqy, nxq, nyq;
  logic [COORD_W-1:0] x, y, nx, ny;
  logic [5:0]         dir;
  logic               kill;

  assign {vld, ent, yq, xq, y, x, dir} = slot_q;
  assign slot_o = slot_q;

  // Sub-step counters reload from the direction magnitudes once both run out.
  assign eqx = (xq == 2'd0 && yq == 2'd0) ? dir[1:0] : xq;
  assign eqy = (xq == 2'd0 && yq == 2'd0) ? dir[4:3] : yq;

  always_comb begin
    nx = x; ny = y; nxq = 2'd0; nyq = 2'd0; kill = 1'b0;
    if (eqx != 2'd0) begin
      nxq = eqx - 2'd1;
      nyq = eqy;
      if (dir[2]) begin
        if (x == '0) begin nx = XMAX; kill = (WRAP_MODE == 0); end
        else nx = x - 1'b1;
      end else begin
        if (x == XMAX) begin nx = '0; kill = (WRAP_MODE == 0); end
        else nx = x + 1'b1;
      end
    end else if (eqy != 2'd0) begin
      nyq = eqy - 2'd1;
      if (dir[5]) begin
        if (y == '0) begin ny = YMAX; kill = (WRAP_MODE == 0); end
        else ny = y - 1'b1;
      end else begin
        if (y == YMAX) begin ny = '0; kill = (WRAP_MODE == 0); end
        else ny = y + 1'b1;
      end
    end
  end

  // A delete aimed at an empty slot falls through so a same-cycle allocation can land.
  always_comb begin
    slot_d = slot_q;
    age_d  = age_q;
    if (del_i && vld) begin
      slot_d = '0;
      age_d  = '0;
    end else if (alloc_i) begin
      slot_d = new_i;
      age_d  = '0;
    end else if (tick_i && vld) begin
      if ((LIFETIME != 0 && age_q == AGE_LAST) || kill) begin
        slot_d = '0;
        age_d  = '0;
      end else begin
        slot_d = {1'b1, ent, nyq, nxq, ny, nx, dir};
        age_d  = age_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
      age_q  <= '0;
    end else begin
      slot_q <= slot_d;
      age_q  <= age_d;
    end
  end
endmodule

module shot_pool #(
  parameter int MAX_SHOTS   = 10,
  parameter int COORD_W     = 10,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int WRAP_MODE   = 1,
  parameter int LIFETIME    = 60,
  parameter int COOLDOWN    = 8,
  parameter int ENTITY_SIZE = 2*COORD_W+14,
  parameter int AW          = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1,
  parameter int CW          = $clog2(MAX_SHOTS+1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           move_tick,
  input  logic                           shoot,
  input  logic [2:0]                     entity_byte,
  input  logic [5:0]                     direction,
  input  logic [COORD_W-1:0]             xtip,
  input  logic [COORD_W-1:0]             ytip,
  input  logic                           delete_shot,
  input  logic [AW-1:0]                  delete_addr,
  output logic [MAX_SHOTS*ENTITY_SIZE-1:0] shots_data,
  output logic [MAX_SHOTS-1:0]           active_mask,
  output logic [CW-1:0]                  active_count,
  output logic                           full,
  output logic                           fire_accepted,
  output logic                           fire_dropped
);
  localparam int ES    = ENTITY_SIZE;
  localparam int AGE_W = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
  localparam int CDW   = (COOLDOWN > 0) ? $clog2(COOLDOWN+1) : 1;

  logic                 shoot_q;
  logic [CDW-1:0]       cool_q, cool_d;
  logic                 acc_q, drp_q;
  logic                 fire_edge, accept;
  logic [MAX_SHOTS-1:0] vld, free_oh, del_oh;
  logic [CW-1:0]        cnt;
  logic [ES-1:0]        new_slot;

  assign new_slot  = {1'b1, entity_byte, 2'b00, 2'b00, ytip, xtip, direction};
  assign fire_edge = shoot & ~shoot_q;
  assign accept    = fire_edge && (cool_q == '0) && !full;

  always_comb begin
    free_oh = '0;
    del_oh  = '0;
    cnt     = '0;
    for (int i = MAX_SHOTS-1; i >= 0; i--) begin
      if (!vld[i]) free_oh = MAX_SHOTS'(1) << i;
      del_oh[i] = delete_shot && (int'(delete_addr) == i);
      cnt = cnt + CW'(vld[i]);
    end
  end

  always_comb begin
    cool_d = cool_q;
    if (accept)            cool_d = CDW'(COOLDOWN);
    else if (cool_q != '0) cool_d = cool_q - 1'b1;
  end

  for (genvar g = 0; g < MAX_SHOTS; g++) begin : g_slot
    shot_slot #(
      .COORD_W(COORD_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
      .WRAP_MODE(WRAP_MODE), .LIFETIME(LIFETIME), .AGE_W(AGE_W), .ES(ES)
    ) u_slot (
      .clk(clk), .reset_n(reset_n),
      .alloc_i(accept && free_oh[g]), .del_i(del_oh[g]), .tick_i(move_tick),
      .new_i(new_slot), .slot_o(shots_data[g*ES +: ES])
    );
    assign vld[g] = shots_data[g*ES + ES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shoot_q <= 1'b0;
      cool_q  <= '0;
      acc_q   <= 1'b0;
      drp_q   <= 1'b0;
    end else begin
      shoot_q <= shoot;
      cool_q  <= cool_d;
      acc_q   <= accept;
      drp_q   <= fire_edge && !accept;
    end
  end

  assign active_mask   = vld;
  assign active_count  = cnt;
  assign full          = &vld;
  assign fire_accepted = acc_q;
  assign fire_dropped  = drp_q;
endmodule

// File: tb/tb_shot_pool.sv
// Directed bench for shot_pool: default instance (wrap, long life) and a no-wrap/LIFETIME=4 instance
// share one stimulus stream.

module tb_shot_pool;
  localparam int N  = 10;
  localparam int ES = 34;

  logic clk = 1'b0, reset_n = 1'b0;
  logic move_tick = 0, shoot = 0, delete_shot = 0;
  logic [2:0] entity_byte = 0;
  logic [5:0] direction = 0;
  logic [9:0] xtip = 0, ytip = 0;
  logic [3:0] delete_addr = 0;

  logic [N*ES-1:0] data_a, data_b;
  logic [N-1:0]    mask_a, mask_b;
  logic [3:0]      cnt_a, cnt_b;
  logic            full_a, full_b, acc_a, acc_b, drp_a, drp_b;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  shot_pool u_a (
    .clk(clk), .reset_n(reset_n), .move_tick(move_tick), .shoot(shoot), .entity_byte(entity_byte),
    .direction(direction), .xtip(xtip), .ytip(ytip), .delete_shot(delete_shot), .delete_addr(delete_addr),
    .shots_data(data_a), .active_mask(mask_a), .active_count(cnt_a), .full(full_a),
    .fire_accepted(acc_a), .fire_dropped(drp_a));

  shot_pool #(.WRAP_MODE(0), .LIFETIME(4)) u_b (
    .clk(clk), .reset_n(reset_n), .move_tick(move_tick), .shoot(shoot), .entity_byte(entity_byte),
    .direction(direction), .xtip(xtip), .ytip(ytip), .delete_shot(delete_shot), .delete_addr(delete_addr),
    .shots_data(data_b), .active_mask(mask_b), .active_count(cnt_b), .full(full_b),
    .fire_accepted(acc_b), .fire_dropped(drp_b));

  typedef struct {
    logic [5:0] dir;
    logic [9:0] x0, y0;
    int         ticks;
    logic [9:0] ex, ey;
    logic       vb;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; shoot = 0; move_tick = 0; delete_shot = 0; delete_addr = 0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic tick();
    move_tick = 1; cycle(); move_tick = 0;
  endtask

  task automatic fire(input string nm, input logic ea, input logic ed);
    shoot = 1; cycle();
    chk({nm, "_acc"}, 64'(acc_a), 64'(ea));
    chk({nm, "_drp"}, 64'(drp_a), 64'(ed));
    shoot = 0; repeat (9) cycle();
  endtask

  function automatic logic [ES-1:0] slot(input logic [N*ES-1:0] d, input int i);
    return d[i*ES +: ES];
  endfunction

  initial begin
    logic [ES-1:0] s;
    int n;
    int gaps[3];
    tbl[0]  = '{6'b000001, 10'd100, 10'd50,  0, 10'd100, 10'd50,  1'b1};
    tbl[1]  = '{6'b010011, 10'd100, 10'd50,  5, 10'd103, 10'd52,  1'b0};
    tbl[2]  = '{6'b010011, 10'd100, 10'd50,  3, 10'd103, 10'd50,  1'b1};
    tbl[3]  = '{6'b110000, 10'd100, 10'd50,  2, 10'd100, 10'd48,  1'b1};
    tbl[4]  = '{6'b000101, 10'd0,   10'd50,  1, 10'd639, 10'd50,  1'b0};
    tbl[5]  = '{6'b000001, 10'd639, 10'd50,  1, 10'd0,   10'd50,  1'b0};
    tbl[6]  = '{6'b000000, 10'd100, 10'd50,  3, 10'd100, 10'd50,  1'b1};
    tbl[7]  = '{6'b001000, 10'd100, 10'd479, 1, 10'd100, 10'd0,   1'b0};
    tbl[8]  = '{6'b000011, 10'd100, 10'd50,  7, 10'd107, 10'd50,  1'b0};
    tbl[9]  = '{6'b101110, 10'd100, 10'd50,  3, 10'd98,  10'd49,  1'b1};
    tbl[10] = '{6'b101000, 10'd100, 10'd0,   1, 10'd100, 10'd479, 1'b0};

    // Reset state, then first shot with a same-cycle delete aimed at the empty slot 0
    do_reset();
    chk("rst_data", 64'(data_a != '0), 64'd0);
    chk("rst_mask", 64'(mask_a), 64'd0);
    chk("rst_cnt", 64'(cnt_a), 64'd0);
    chk("rst_full", 64'(full_a), 64'd0);
    chk("rst_pulse", 64'({acc_a, drp_a}), 64'd0);
    xtip = 10'd100; ytip = 10'd50; direction = 6'b000001; entity_byte = 3'd5;
    delete_shot = 1; delete_addr = 0; shoot = 1;
    cycle();
    chk("t1_acc", 64'(acc_a), 64'd1);
    chk("t1_slot0", 64'(slot(data_a, 0)), 64'({1'b1, 3'd5, 4'b0, 10'd50, 10'd100, 6'b000001}));
    chk("t1_cnt", 64'(cnt_a), 64'd1);
    delete_shot = 0; shoot = 0;
    cycle();
    chk("t1_acc_drop", 64'(acc_a), 64'd0);

    // Holding the button gives one shot
    do_reset();
    shoot = 1; n = 0;
    for (int k = 0; k < 20; k++) begin cycle(); if (acc_a) n++; end
    chk("hold_shots", 64'(n), 64'd1);
    chk("hold_cnt", 64'(cnt_a), 64'd1);
    shoot = 0;

    // Re-press after a gap: accepted only once COOLDOWN+1 cycles have passed
    gaps = '{5, 8, 9};
    foreach (gaps[g]) begin
      do_reset();
      shoot = 1; cycle(); shoot = 0;
      repeat (gaps[g]-1) cycle();
      shoot = 1; cycle();
      chk($sformatf("gap%0d_acc", gaps[g]), 64'(acc_a), 64'(gaps[g] >= 9));
      chk($sformatf("gap%0d_drp", gaps[g]), 64'(drp_a), 64'(gaps[g] < 9));
      chk($sformatf("gap%0d_cnt", gaps[g]), 64'(cnt_a), 64'(gaps[g] >= 9 ? 2 : 1));
      shoot = 0;
    end

    // Movement table
    foreach (tbl[i]) begin
      do_reset();
      direction = tbl[i].dir; xtip = tbl[i].x0; ytip = tbl[i].y0; entity_byte = 3'(i);
      shoot = 1; cycle(); shoot = 0;
      for (int t = 0; t < tbl[i].ticks; t++) tick();
      s = slot(data_a, 0);
      chk($sformatf("v%0d_x", i), 64'(s[15:6]), 64'(tbl[i].ex));
      chk($sformatf("v%0d_y", i), 64'(s[25:16]), 64'(tbl[i].ey));
      chk($sformatf("v%0d_valid_a", i), 64'(s[33]), 64'd1);
      chk($sformatf("v%0d_valid_b", i), 64'(mask_b[0]), 64'(tbl[i].vb));
    end

    // Lifetime boundary on the LIFETIME=4 instance
    do_reset();
    direction = 6'b000000; xtip = 10'd10; ytip = 10'd10;
    shoot = 1; cycle(); shoot = 0;
    repeat (3) tick();
    chk("life_t3_b", 64'(cnt_b), 64'd1);
    tick();
    chk("life_t4_b", 64'(cnt_b), 64'd0);
    chk("life_t4_data_b", 64'(slot(data_b, 0)), 64'd0);
    chk("life_t4_a", 64'(cnt_a), 64'd1);

    // Fill all slots, then overflow
    do_reset();
    direction = 6'b000000; xtip = 10'd200; ytip = 10'd100;
    for (int k = 0; k < N; k++) begin
      entity_byte = 3'(k);
      fire($sformatf("fill%0d", k), 1'b1, 1'b0);
    end
    chk("full_a", 64'(full_a), 64'd1);
    chk("full_cnt", 64'(cnt_a), 64'd10);
    chk("full_mask", 64'(mask_a), 64'h3FF);
    chk("full_b", 64'(full_b), 64'd1);
    fire("over", 1'b0, 1'b1);
    chk("over_cnt", 64'(cnt_a), 64'd10);

    // Slot freed this cycle is not reusable by a same-cycle fire
    delete_shot = 1; delete_addr = 4'd5; shoot = 1;
    cycle();
    chk("freed_drp", 64'(drp_a), 64'd1);
    chk("freed_cnt", 64'(cnt_a), 64'd9);
    chk("freed_slot5", 64'(slot(data_a, 5)), 64'd0);
    delete_shot = 0; shoot = 0; cycle();
    entity_byte = 3'd7; shoot = 1; cycle();
    chk("refill_acc", 64'(acc_a), 64'd1);
    chk("refill_slot5", 64'(slot(data_a, 5)), 64'({1'b1, 3'd7, 4'b0, 10'd100, 10'd200, 6'b0}));
    shoot = 0; repeat (10) cycle();

    // Delete coincident with a move tick, then an out-of-range address
    delete_shot = 1; delete_addr = 4'd2; move_tick = 1;
    cycle();
    delete_shot = 0; move_tick = 0;
    chk("del2_slot", 64'(slot(data_a, 2)), 64'd0);
    chk("del2_cnt", 64'(cnt_a), 64'd9);
    chk("del2_cnt_b", 64'(cnt_b), 64'd9);
    delete_shot = 1; delete_addr = 4'd12;
    cycle();
    delete_shot = 0;
    chk("del12_mask", 64'(mask_a), 64'h3FB);

    // Asynchronous reset mid-flight, no pulses while held
    reset_n = 0; #1;
    chk("arst_data", 64'(data_a != '0), 64'd0);
    chk("arst_cnt", 64'(cnt_a), 64'd0);
    shoot = 1; cycle();
    chk("arst_pulse", 64'({acc_a, drp_a, acc_b, drp_b}), 64'd0);
    shoot = 0; reset_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
